// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input conditioner: button bit positions, PS/2 scan codes,
// held-key register indices and the coin FSM state type.
package arcade_input_pkg;

   localparam int BIT_RIGHT = 0;
   localparam int BIT_LEFT  = 1;
   localparam int BIT_DOWN  = 2;
   localparam int BIT_UP    = 3;
   localparam int BIT_FIRE  = 4;
   localparam int BIT_JUMP  = 5;
   localparam int BIT_START = 6;
   localparam int BIT_COIN  = 7;

   // Scan codes as {extended, code}
   localparam logic [8:0] SC_P1_UP      = 9'h175;
   localparam logic [8:0] SC_P1_DOWN    = 9'h172;
   localparam logic [8:0] SC_P1_LEFT    = 9'h16B;
   localparam logic [8:0] SC_P1_RIGHT   = 9'h174;
   localparam logic [8:0] SC_P1_JUMP    = 9'h029;
   localparam logic [8:0] SC_P1_FIRE    = 9'h014;
   localparam logic [8:0] SC_P1_START_A = 9'h005;
   localparam logic [8:0] SC_P1_START_B = 9'h016;
   localparam logic [8:0] SC_P1_COIN    = 9'h02E;
   localparam logic [8:0] SC_P2_UP      = 9'h02D;
   localparam logic [8:0] SC_P2_DOWN    = 9'h02B;
   localparam logic [8:0] SC_P2_LEFT    = 9'h023;
   localparam logic [8:0] SC_P2_RIGHT   = 9'h034;
   localparam logic [8:0] SC_P2_JUMP    = 9'h01B;
   localparam logic [8:0] SC_P2_FIRE    = 9'h01C;
   localparam logic [8:0] SC_P2_START_A = 9'h006;
   localparam logic [8:0] SC_P2_START_B = 9'h01E;
   localparam logic [8:0] SC_P2_COIN    = 9'h036;

   localparam int K_P1_UP      = 0;
   localparam int K_P1_DOWN    = 1;
   localparam int K_P1_LEFT    = 2;
   localparam int K_P1_RIGHT   = 3;
   localparam int K_P1_JUMP    = 4;
   localparam int K_P1_FIRE    = 5;
   localparam int K_P1_START_A = 6;
   localparam int K_P1_START_B = 7;
   localparam int K_P1_COIN    = 8;
   localparam int K_P2_UP      = 9;
   localparam int K_P2_DOWN    = 10;
   localparam int K_P2_LEFT    = 11;
   localparam int K_P2_RIGHT   = 12;
   localparam int K_P2_JUMP    = 13;
   localparam int K_P2_FIRE    = 14;
   localparam int K_P2_START_A = 15;
   localparam int K_P2_START_B = 16;
   localparam int K_P2_COIN    = 17;
   localparam int NUM_KEYS     = 18;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GUARD
   } coin_state_t;

   // One-hot key register select; all zero for unmapped codes
   function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [8:0] sc);
      logic [NUM_KEYS-1:0] hit;
      hit = '0;
      case (sc)
         SC_P1_UP:      hit[K_P1_UP]      = 1'b1;
         SC_P1_DOWN:    hit[K_P1_DOWN]    = 1'b1;
         SC_P1_LEFT:    hit[K_P1_LEFT]    = 1'b1;
         SC_P1_RIGHT:   hit[K_P1_RIGHT]   = 1'b1;
         SC_P1_JUMP:    hit[K_P1_JUMP]    = 1'b1;
         SC_P1_FIRE:    hit[K_P1_FIRE]    = 1'b1;
         SC_P1_START_A: hit[K_P1_START_A] = 1'b1;
         SC_P1_START_B: hit[K_P1_START_B] = 1'b1;
         SC_P1_COIN:    hit[K_P1_COIN]    = 1'b1;
         SC_P2_UP:      hit[K_P2_UP]      = 1'b1;
         SC_P2_DOWN:    hit[K_P2_DOWN]    = 1'b1;
         SC_P2_LEFT:    hit[K_P2_LEFT]    = 1'b1;
         SC_P2_RIGHT:   hit[K_P2_RIGHT]   = 1'b1;
         SC_P2_JUMP:    hit[K_P2_JUMP]    = 1'b1;
         SC_P2_FIRE:    hit[K_P2_FIRE]    = 1'b1;
         SC_P2_START_A: hit[K_P2_START_A] = 1'b1;
         SC_P2_START_B: hit[K_P2_START_B] = 1'b1;
         SC_P2_COIN:    hit[K_P2_COIN]    = 1'b1;
         default:       hit               = '0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus per-bit stable-count debounce.
// Counters exist only when INPUT_DEBOUNCE_EN is defined; otherwise the synchronised bits pass through.
module input_debounce #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CYCLES = 30000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_db
);

   if (CYCLES < 1) begin : g_bad_cycles
      $error("input_debounce: CYCLES must be at least 1");
   end

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

`ifdef INPUT_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic [CW-1:0]    r_cnt [WIDTH];
   logic [WIDTH-1:0] r_db;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_db <= '0;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CW'(CYCLES - 1)) begin
               r_db[i]  <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign o_db = r_db;
`else
   assign o_db = r_sync2;
`endif

endmodule

// File: rtl/arcade_input_cond.sv
// Keyboard decode, joystick debounce and coin pulse shaping ahead of the core's JOY/JOY2 ports.
// Optional debounce counters are enabled by defining INPUT_DEBOUNCE_EN.
module arcade_input_cond
   import arcade_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 30000,
   parameter int unsigned COIN_CYCLES     = 3000000,
   parameter int unsigned GUARD_CYCLES    = 3000000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [7:0]  joy_a,
   input  logic [7:0]  joy_b,
   output logic [7:0]  JOY,
   output logic [7:0]  JOY2,
   output logic        coin_busy
);

   localparam int unsigned CNT_MAX = (COIN_CYCLES > GUARD_CYCLES) ? COIN_CYCLES : GUARD_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   logic                r_toggle;
   logic [NUM_KEYS-1:0] r_keys;
   logic [NUM_KEYS-1:0] w_hit;
   logic                w_evt;
   logic [7:0]          w_db_a;
   logic [7:0]          w_db_b;
   logic [6:0]          w_p1;
   logic [6:0]          w_p2;
   logic                w_coin_lvl;
   logic                r_coin_lvl;
   logic                w_coin_req;
   coin_state_t         r_state;
   coin_state_t         w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nxt;

   assign w_evt = ps2_key[10] ^ r_toggle;
   assign w_hit = key_onehot(ps2_key[8:0]);

   // Toggle copy loads even in reset so an event coinciding with reset is not replayed later
   always_ff @(posedge clk_sys) begin
      r_toggle <= ps2_key[10];
      if (reset) begin
         r_keys <= '0;
      end else if (w_evt) begin
         r_keys <= (r_keys & ~w_hit) | (w_hit & {NUM_KEYS{ps2_key[9]}});
      end
   end

   input_debounce #(
      .WIDTH  (8),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_a (
      .i_clk   (clk_sys),
      .i_reset (reset),
      .i_raw   (joy_a),
      .o_db    (w_db_a)
   );

   input_debounce #(
      .WIDTH  (8),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_b (
      .i_clk   (clk_sys),
      .i_reset (reset),
      .i_raw   (joy_b),
      .o_db    (w_db_b)
   );

   always_comb begin
      w_p1 = '0;
      w_p1[BIT_RIGHT] = r_keys[K_P1_RIGHT];
      w_p1[BIT_LEFT]  = r_keys[K_P1_LEFT];
      w_p1[BIT_DOWN]  = r_keys[K_P1_DOWN];
      w_p1[BIT_UP]    = r_keys[K_P1_UP];
      w_p1[BIT_FIRE]  = r_keys[K_P1_FIRE];
      w_p1[BIT_JUMP]  = r_keys[K_P1_JUMP];
      w_p1[BIT_START] = r_keys[K_P1_START_A] | r_keys[K_P1_START_B];
      w_p1            = w_p1 | w_db_a[BIT_START:BIT_RIGHT];

      w_p2 = '0;
      w_p2[BIT_RIGHT] = r_keys[K_P2_RIGHT];
      w_p2[BIT_LEFT]  = r_keys[K_P2_LEFT];
      w_p2[BIT_DOWN]  = r_keys[K_P2_DOWN];
      w_p2[BIT_UP]    = r_keys[K_P2_UP];
      w_p2[BIT_FIRE]  = r_keys[K_P2_FIRE];
      w_p2[BIT_JUMP]  = r_keys[K_P2_JUMP];
      w_p2[BIT_START] = r_keys[K_P2_START_A] | r_keys[K_P2_START_B];
      w_p2            = w_p2 | w_db_b[BIT_START:BIT_RIGHT];
   end

   assign w_coin_lvl = r_keys[K_P1_COIN] | r_keys[K_P2_COIN] | w_db_a[BIT_COIN] | w_db_b[BIT_COIN];
   assign w_coin_req = w_coin_lvl & ~r_coin_lvl;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_coin_req) begin
               w_state_nxt = PULSE;
               w_cnt_nxt   = CW'(COIN_CYCLES - 1);
            end
         end
         PULSE: begin
            if (r_cnt == '0) begin
               w_state_nxt = GUARD;
               w_cnt_nxt   = CW'(GUARD_CYCLES - 1);
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         GUARD: begin
            if (r_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_coin_lvl <= 1'b0;
         JOY        <= '0;
         JOY2       <= '0;
         coin_busy  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_coin_lvl <= w_coin_lvl;
         JOY        <= {r_state == PULSE, w_p1};
         JOY2       <= {1'b0, w_p2};
         coin_busy  <= r_state != IDLE;
      end
   end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Randomised self-checking bench for arcade_input_cond against a scan-code/elapsed-time model.
// Debounce expectations follow INPUT_DEBOUNCE_EN exactly as the DUT build does.
module tb_arcade_input_cond;

   localparam int D = 16;
   localparam int C = 40;
   localparam int G = 30;
`ifdef INPUT_DEBOUNCE_EN
   localparam int LAT = D + 3;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [7:0]  joy_a;
   logic [7:0]  joy_b;
   logic [7:0]  JOY;
   logic [7:0]  JOY2;
   logic        coin_busy;

   int checks   = 0;
   int failures = 0;

   logic [8:0] keytab [18] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h014, 9'h005, 9'h016,
                               9'h02E, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01B, 9'h01C, 9'h006,
                               9'h01E, 9'h036};

   always #5 clk = ~clk;

   arcade_input_cond #(
      .DEBOUNCE_CYCLES (D),
      .COIN_CYCLES     (C),
      .GUARD_CYCLES    (G)
   ) dut (
      .clk_sys   (clk),
      .reset     (reset),
      .ps2_key   (ps2_key),
      .joy_a     (joy_a),
      .joy_b     (joy_b),
      .JOY       (JOY),
      .JOY2      (JOY2),
      .coin_busy (coin_busy)
   );

   // Reference model: held keys indexed by scan code, coin as time since pulse start
   bit         m_key [512];
   logic       m_tog = 1'b0;
   logic [7:0] m_s1a = '0, m_s2a = '0, m_dba = '0;
   logic [7:0] m_s1b = '0, m_s2b = '0, m_dbb = '0;
   int         m_runa [8];
   int         m_runb [8];
   logic       m_lvl = 1'b0;
   bit         m_act = 1'b0;
   int         m_t = 0;
   logic [7:0] exp_joy = '0, exp_joy2 = '0;
   logic       exp_busy = 1'b0;

   function automatic logic [6:0] pvec(input int p);
      logic [6:0] v;
      if (p == 1) begin
         v = {m_key[9'h005] | m_key[9'h016], m_key[9'h029], m_key[9'h014], m_key[9'h175],
              m_key[9'h172], m_key[9'h16B], m_key[9'h174]};
      end else begin
         v = {m_key[9'h006] | m_key[9'h01E], m_key[9'h01B], m_key[9'h01C], m_key[9'h02D],
              m_key[9'h02B], m_key[9'h023], m_key[9'h034]};
      end
      return v;
   endfunction

   always @(posedge clk) begin : model
      logic [7:0] da, db;
      logic       lvl;
`ifdef INPUT_DEBOUNCE_EN
      da = m_dba;
      db = m_dbb;
`else
      da = m_s2a;
      db = m_s2b;
`endif
      lvl = m_key[9'h02E] | m_key[9'h036] | da[7] | db[7];
      if (reset) begin
         exp_joy = '0; exp_joy2 = '0; exp_busy = 1'b0;
         m_act = 1'b0; m_t = 0; m_lvl = 1'b0;
         m_s1a = '0; m_s2a = '0; m_dba = '0;
         m_s1b = '0; m_s2b = '0; m_dbb = '0;
         for (int i = 0; i < 8; i++) begin m_runa[i] = 0; m_runb[i] = 0; end
         for (int i = 0; i < 512; i++) m_key[i] = 1'b0;
      end else begin
         exp_joy  = {m_act && (m_t < C), pvec(1) | da[6:0]};
         exp_joy2 = {1'b0, pvec(2) | db[6:0]};
         exp_busy = m_act;
         if (m_act) begin
            m_t++;
            if (m_t == C + G) m_act = 1'b0;
         end else if (lvl && !m_lvl) begin
            m_act = 1'b1;
            m_t   = 0;
         end
         m_lvl = lvl;
         // A bit flips after D consecutive cycles of disagreement
         for (int i = 0; i < 8; i++) begin
            if (m_s2a[i] != m_dba[i]) begin
               m_runa[i]++;
               if (m_runa[i] == D) begin m_dba[i] = m_s2a[i]; m_runa[i] = 0; end
            end else m_runa[i] = 0;
            if (m_s2b[i] != m_dbb[i]) begin
               m_runb[i]++;
               if (m_runb[i] == D) begin m_dbb[i] = m_s2b[i]; m_runb[i] = 0; end
            end else m_runb[i] = 0;
         end
         m_s2a = m_s1a; m_s1a = joy_a;
         m_s2b = m_s1b; m_s1b = joy_b;
         if (ps2_key[10] != m_tog) m_key[ps2_key[8:0]] = ps2_key[9];
      end
      m_tog = ps2_key[10];
   end

   task automatic ps2_event(input logic [8:0] sc, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, sc};
   endtask

   task automatic release_all();
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         ps2_event(keytab[i], 1'b0);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if ({JOY, JOY2, coin_busy} !== 17'h0) begin
               failures++;
               $display("FAIL reset_hold got=%h_%h_%b want=0", JOY, JOY2, coin_busy);
            end
         end
         joy_a = 8'($urandom);
         joy_b = 8'($urandom);
         ps2_event(9'h175, 1'b1); // event during reset must be discarded
      end
      @(negedge clk);
      reset = 1'b0;
      joy_a = '0;
      joy_b = '0;
      repeat (LAT + 3) @(negedge clk);
      checks++;
      if ({JOY, JOY2, coin_busy} !== 17'h0) begin
         failures++;
         $display("FAIL reset_release got=%h_%h_%b want=0", JOY, JOY2, coin_busy);
      end
   endtask

   task automatic test_keyboard();
      @(negedge clk);
      ps2_event(9'h175, 1'b1);
      @(negedge clk);
      checks++;
      if (JOY[3] !== 1'b0) begin
         failures++; $display("FAIL kbd_up_early got=%b want=0", JOY[3]);
      end
      @(negedge clk);
      checks++;
      if (JOY[3] !== 1'b1) begin
         failures++; $display("FAIL kbd_up_make got=%b want=1", JOY[3]);
      end
      ps2_event(9'h175, 1'b0);
      @(negedge clk);
      checks++;
      if (JOY[3] !== 1'b1) begin
         failures++; $display("FAIL kbd_up_hold got=%b want=1", JOY[3]);
      end
      @(negedge clk);
      checks++;
      if (JOY[3] !== 1'b0) begin
         failures++; $display("FAIL kbd_up_break got=%b want=0", JOY[3]);
      end
      for (int i = 0; i < 80; i++) begin
         logic [8:0] sc;
         if ($urandom_range(3) != 0) sc = keytab[$urandom_range(17)];
         else sc = 9'($urandom);
         if ($urandom_range(1) == 0) ps2_event(sc, 1'($urandom));
         @(negedge clk);
         checks++;
         if ({JOY, JOY2, coin_busy} !== {exp_joy, exp_joy2, exp_busy}) begin
            failures++;
            $display("FAIL kbd_rand got=%h_%h_%b want=%h_%h_%b", JOY, JOY2, coin_busy,
                     exp_joy, exp_joy2, exp_busy);
         end
      end
      release_all();
      repeat (C + G + 5) @(negedge clk);
   endtask

   task automatic test_debounce();
`ifdef INPUT_DEBOUNCE_EN
      joy_a[4] = 1'b1;
      repeat (D - 2) @(negedge clk);
      joy_a[4] = 1'b0;
      for (int k = 0; k < D + 10; k++) begin
         @(negedge clk);
         checks++;
         if (JOY[4] !== 1'b0) begin
            failures++; $display("FAIL deb_glitch cycle=%0d got=%b want=0", k, JOY[4]);
         end
      end
`endif
      joy_a[4] = 1'b1;
      for (int k = 1; k <= D + 10; k++) begin
         @(negedge clk);
         if (k == LAT - 1 || k == LAT) begin
            checks++;
            if (JOY[4] !== (k == LAT)) begin
               failures++;
               $display("FAIL deb_latency edge=%0d got=%b want=%b", k, JOY[4], k == LAT);
            end
         end
      end
      joy_a[4] = 1'b0;
      for (int i = 0; i < 300; i++) begin
         int b;
         if ($urandom_range(7) == 0) begin b = $urandom_range(7); joy_a[b] = ~joy_a[b]; end
         if ($urandom_range(7) == 0) begin b = $urandom_range(7); joy_b[b] = ~joy_b[b]; end
         @(negedge clk);
         checks++;
         if ({JOY, JOY2, coin_busy} !== {exp_joy, exp_joy2, exp_busy}) begin
            failures++;
            $display("FAIL deb_rand got=%h_%h_%b want=%h_%h_%b", JOY, JOY2, coin_busy,
                     exp_joy, exp_joy2, exp_busy);
         end
      end
      joy_a = '0;
      joy_b = '0;
      repeat (LAT + C + G + 5) @(negedge clk);
   endtask

   // Event driven at k=0 sets the key at edge 1, the FSM enters PULSE at edge 2, JOY[7] at edge 3
   task automatic coin_window(input int first, input int span, input string tag);
      for (int k = 1; k <= span; k++) begin
         @(negedge clk);
         checks++;
         if ({JOY[7], coin_busy} !== {1'(k >= first && k < first + C),
                                      1'(k >= first && k < first + C + G)}) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b%b want=%b%b", tag, k, JOY[7], coin_busy,
                     k >= first && k < first + C, k >= first && k < first + C + G);
         end
         if (tag == "coin_first" && k == 10) ps2_event(9'h02E, 1'b0);
         if (tag == "coin_first" && k == 3 + C + 5) ps2_event(9'h02E, 1'b1);
      end
   endtask

   task automatic test_coin();
      @(negedge clk);
      ps2_event(9'h02E, 1'b1);
      coin_window(3, 3 + C + G + 10, "coin_first");
      ps2_event(9'h02E, 1'b0);
      repeat (3) @(negedge clk);
      ps2_event(9'h02E, 1'b1);
      coin_window(3, 3 + C + G + 5, "coin_again");
      ps2_event(9'h02E, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_joy_coin(input logic both);
      int highs = 0;
      int rises = 0;
      logic prev = 1'b0;
      joy_b[7] = 1'b1;
      if (both) joy_a[7] = 1'b1;
      for (int k = 0; k < LAT + C + G + 10; k++) begin
         @(negedge clk);
         if (JOY[7]) highs++;
         if (JOY[7] && !prev) rises++;
         prev = JOY[7];
         checks++;
         if (JOY2[7] !== 1'b0) begin
            failures++; $display("FAIL joy2_bit7 cycle=%0d got=%b want=0", k, JOY2[7]);
         end
         checks++;
         if ({JOY, JOY2, coin_busy} !== {exp_joy, exp_joy2, exp_busy}) begin
            failures++;
            $display("FAIL joy_coin got=%h_%h_%b want=%h_%h_%b", JOY, JOY2, coin_busy,
                     exp_joy, exp_joy2, exp_busy);
         end
      end
      checks++;
      if (highs != C || rises != 1) begin
         failures++;
         $display("FAIL joy_coin_pulse both=%b got=%0d/%0d want=%0d/1", both, highs, rises, C);
      end
      joy_a = '0;
      joy_b = '0;
      repeat (LAT + 3) @(negedge clk);
   endtask

   task automatic test_reset_mid_pulse();
      int guard = 0;
      @(negedge clk);
      ps2_event(9'h016, 1'b1);
      @(negedge clk);
      ps2_event(9'h036, 1'b1);
      while (JOY[7] !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
      checks++;
      if (JOY[7] !== 1'b1 || JOY[6] !== 1'b1) begin
         failures++; $display("FAIL rst_mid_setup got=%h want=c0", JOY);
      end
      repeat (5) @(negedge clk);
      reset = 1'b1;
      ps2_event(9'h029, 1'b1);
      @(negedge clk);
      checks++;
      if ({JOY, JOY2, coin_busy} !== 17'h0) begin
         failures++;
         $display("FAIL rst_mid got=%h_%h_%b want=0", JOY, JOY2, coin_busy);
      end
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if ({JOY, JOY2, coin_busy} !== 17'h0) begin
            failures++;
            $display("FAIL rst_after cycle=%0d got=%h_%h_%b want=0", k, JOY, JOY2, coin_busy);
         end
      end
      ps2_event(9'h016, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (JOY !== 8'h40 || JOY !== exp_joy) begin
         failures++; $display("FAIL rst_new_make got=%h want=40", JOY);
      end
      release_all();
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         int b;
         reset = ($urandom_range(199) == 0);
         if ($urandom_range(3) == 0) begin
            if ($urandom_range(3) != 0) ps2_event(keytab[$urandom_range(17)], 1'($urandom));
            else ps2_event(9'($urandom), 1'($urandom));
         end
         if ($urandom_range(9) == 0) begin b = $urandom_range(7); joy_a[b] = ~joy_a[b]; end
         if ($urandom_range(9) == 0) begin b = $urandom_range(7); joy_b[b] = ~joy_b[b]; end
         @(negedge clk);
         checks++;
         if ({JOY, JOY2, coin_busy} !== {exp_joy, exp_joy2, exp_busy}) begin
            failures++;
            $display("FAIL random cycle=%0d got=%h_%h_%b want=%h_%h_%b", i, JOY, JOY2,
                     coin_busy, exp_joy, exp_joy2, exp_busy);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      ps2_key = '0;
      joy_a   = '0;
      joy_b   = '0;
      test_reset();
      test_keyboard();
      test_debounce();
      test_coin();
      test_joy_coin(1'b0);
      repeat (C + G + 5) @(negedge clk);
      test_joy_coin(1'b1);
      repeat (C + G + 5) @(negedge clk);
      test_reset_mid_pulse();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
